// File: rtl/uart_prog_loader.sv
// UART-fed program memory: 8N1 bytes received while i_load is high are stored at consecutive
// addresses from 0; the CPU reads the memory combinationally through i_pc.
module uart_prog_loader #(
   parameter int UBRR   = 10415,
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5
)(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_rx,
   input  logic              i_load,
   input  logic [ADDR_W-1:0] i_pc,
   output logic [DATA_W-1:0] o_data_out,
   output logic              o_fe,
   output logic              o_busy,
   output logic [ADDR_W:0]   o_wr_count,
   output logic              o_full
);

   localparam int DEPTH = 2**ADDR_W;
   localparam int CNT_W = (UBRR > 1) ? $clog2(UBRR + 1) : 1;
   localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0]  HALF_BIT   = CNT_W'(UBRR / 2);
   localparam logic [CNT_W-1:0]  FULL_BIT   = CNT_W'(UBRR);
   localparam logic [BIT_W-1:0]  LAST_BIT   = BIT_W'(DATA_W - 1);
   localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAITHI
   } state_t;

   state_t             r_state;
   logic               r_rxMeta;
   logic               r_rxs;
   logic               r_loadPrev;
   logic [CNT_W-1:0]   r_bcnt;
   logic [BIT_W-1:0]   r_bitIdx;
   logic [DATA_W-1:0]  r_shift;
   logic               r_fe;
   logic [ADDR_W:0]    r_wrCount;
   logic [DATA_W-1:0]  r_mem [DEPTH];

   logic w_full;
   logic w_tick;
   logic w_loadRise;
   logic w_wrEn;

   assign w_full     = (r_wrCount == FULL_COUNT);
   assign w_tick     = (r_bcnt == '0);
   assign w_loadRise = i_load & ~r_loadPrev;
   assign w_wrEn     = i_load && (r_state == S_STOP) && w_tick && r_rxs && !w_full;

   // RX is asynchronous to the clock, so it is resynchronised before any decision uses it.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rxMeta <= 1'b1;
         r_rxs    <= 1'b1;
      end else begin
         r_rxMeta <= i_rx;
         r_rxs    <= r_rxMeta;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_loadPrev <= 1'b0;
         r_bcnt     <= '0;
         r_bitIdx   <= '0;
         r_shift    <= '0;
         r_fe       <= 1'b0;
         r_wrCount  <= '0;
      end else begin
         r_loadPrev <= i_load;
         if (!i_load) begin
            r_state <= S_IDLE;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (!r_rxs) begin
                     r_state <= S_START;
                     r_bcnt  <= HALF_BIT;
                  end
               end
               S_START: begin
                  if (!w_tick) begin
                     r_bcnt <= r_bcnt - CNT_W'(1);
                  end else if (!r_rxs) begin
                     r_state  <= S_DATA;
                     r_bcnt   <= FULL_BIT;
                     r_bitIdx <= '0;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
               S_DATA: begin
                  if (!w_tick) begin
                     r_bcnt <= r_bcnt - CNT_W'(1);
                  end else begin
                     r_shift <= {r_rxs, r_shift[DATA_W-1:1]};
                     r_bcnt  <= FULL_BIT;
                     if (r_bitIdx == LAST_BIT) begin
                        r_state <= S_STOP;
                     end else begin
                        r_bitIdx <= r_bitIdx + BIT_W'(1);
                     end
                  end
               end
               S_STOP: begin
                  if (!w_tick) begin
                     r_bcnt <= r_bcnt - CNT_W'(1);
                  end else if (r_rxs) begin
                     if (!w_full) begin
                        r_wrCount <= r_wrCount + (ADDR_W+1)'(1);
                     end
                     r_state <= S_IDLE;
                  end else begin
                     r_fe    <= 1'b1;
                     r_state <= S_WAITHI;
                  end
               end
               S_WAITHI: begin
                  // A held-low line (break) must see a high level before a new frame may start.
                  if (r_rxs) begin
                     r_state <= S_IDLE;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
         if (w_loadRise) begin
            r_wrCount <= '0;
            r_fe      <= 1'b0;
         end
      end
   end

   // Program memory keeps its contents across reset so a downloaded program survives a CPU reset.
   always_ff @(posedge i_clk) begin
      if (w_wrEn) begin
         r_mem[r_wrCount[ADDR_W-1:0]] <= r_shift;
      end
   end

   assign o_data_out = r_mem[i_pc];
   assign o_fe       = r_fe;
   assign o_busy     = (r_state != S_IDLE);
   assign o_wr_count = r_wrCount;
   assign o_full     = w_full;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader: table vectors, random frames against a
// transaction-level memory model, and hand-written reset/glitch/abort/full sequences.
module tb_uart_prog_loader;

   localparam int UBRR    = 15;
   localparam int BIT_CYC = UBRR + 1;
   localparam int ADDR_W  = 5;
   localparam int DEPTH   = 2**ADDR_W;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              rx;
   logic              load;
   logic [ADDR_W-1:0] pc;
   logic [7:0]        dataOut;
   logic              fe;
   logic              busy;
   logic [ADDR_W:0]   wrCount;
   logic              full;

   int testsRun    = 0;
   int testsFailed = 0;

   logic [7:0] modelMem [DEPTH];
   bit         modelValid [DEPTH];
   int         modelCount;
   bit         modelFe;

   typedef struct {
      logic [7:0] data;
      logic       stopBit;
      int         expCount;
      logic       expFe;
   } vec_t;

   vec_t vecs [5];

   uart_prog_loader #(.UBRR(UBRR), .DATA_W(8), .ADDR_W(ADDR_W)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_rx       (rx),
      .i_load     (load),
      .i_pc       (pc),
      .o_data_out (dataOut),
      .o_fe       (fe),
      .o_busy     (busy),
      .o_wr_count (wrCount),
      .o_full     (full)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Sends one 8N1 frame, LSB first, then idles the line high.
   task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
      @(negedge clk);
      rx = 1'b0;
      waitCycles(BIT_CYC);
      for (int i = 0; i < 8; i++) begin
         rx = data[i];
         waitCycles(BIT_CYC);
      end
      rx = stopBit;
      waitCycles(BIT_CYC);
      rx = 1'b1;
      waitCycles(6);
   endtask

   task automatic modelFrame(input logic [7:0] data, input logic stopBit);
      if (load) begin
         if (!stopBit) begin
            modelFe = 1'b1;
         end else if (modelCount < DEPTH) begin
            modelMem[modelCount]   = data;
            modelValid[modelCount] = 1'b1;
            modelCount++;
         end
      end
   endtask

   task automatic sendAndModel(input logic [7:0] data, input logic stopBit);
      applyStimulus(data, stopBit);
      modelFrame(data, stopBit);
   endtask

   task automatic modelLoadRise();
      modelCount = 0;
      modelFe    = 1'b0;
   endtask

   task automatic checkState(input string tag);
      checkOutput({tag, "_count"}, 32'(wrCount), 32'(modelCount));
      checkOutput({tag, "_fe"},    32'(fe),      32'(modelFe));
      checkOutput({tag, "_full"},  32'(full),    32'(modelCount == DEPTH));
      checkOutput({tag, "_busy"},  32'(busy),    32'd0);
   endtask

   task automatic checkMem(input int addr);
      if (modelValid[addr]) begin
         pc = ADDR_W'(addr);
         #1;
         checkOutput($sformatf("mem%0d", addr), 32'(dataOut), 32'(modelMem[addr]));
      end
   endtask

   initial begin
      vecs[0] = '{data: 8'hFE, stopBit: 1'b1, expCount: 1, expFe: 1'b0};
      vecs[1] = '{data: 8'h00, stopBit: 1'b1, expCount: 2, expFe: 1'b0};
      vecs[2] = '{data: 8'hBA, stopBit: 1'b1, expCount: 3, expFe: 1'b0};
      vecs[3] = '{data: 8'h55, stopBit: 1'b0, expCount: 3, expFe: 1'b1};
      vecs[4] = '{data: 8'h20, stopBit: 1'b1, expCount: 4, expFe: 1'b1};

      for (int i = 0; i < DEPTH; i++) begin
         modelValid[i] = 1'b0;
         modelMem[i]   = 8'h00;
      end
      modelCount = 0;
      modelFe    = 1'b0;

      rst_n = 1'b0;
      rx    = 1'b1;
      load  = 1'b0;
      pc    = '0;
      waitCycles(3);
      checkState("reset");
      rst_n = 1'b1;
      waitCycles(2);

      load = 1'b1;
      modelLoadRise();
      waitCycles(2);

      for (int i = 0; i < 5; i++) begin
         applyStimulus(vecs[i].data, vecs[i].stopBit);
         modelFrame(vecs[i].data, vecs[i].stopBit);
         checkOutput($sformatf("tbl%0d_count", i), 32'(wrCount), 32'(vecs[i].expCount));
         checkOutput($sformatf("tbl%0d_fe", i),    32'(fe),      32'(vecs[i].expFe));
         checkOutput($sformatf("tbl%0d_busy", i),  32'(busy),    32'd0);
      end
      for (int a = 0; a < 4; a++) checkMem(a);

      // Reset in the middle of a frame clears the receiver but not the memory.
      @(negedge clk);
      rx = 1'b0;
      waitCycles(40);
      checkOutput("midframe_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_busy",  32'(busy),    32'd0);
      checkOutput("rst_fe",    32'(fe),      32'd0);
      checkOutput("rst_count", 32'(wrCount), 32'd0);
      modelLoadRise();
      rx = 1'b1;
      waitCycles(3);
      rst_n = 1'b1;
      waitCycles(2);
      checkMem(0);
      checkState("postrst");

      // Framing error is sticky until the next Load rise.
      sendAndModel(8'h11, 1'b1);
      sendAndModel(8'h55, 1'b0);
      checkState("fe_set");
      load = 1'b0;
      waitCycles(3);
      load = 1'b1;
      modelLoadRise();
      waitCycles(2);
      checkState("loadrise");

      // Short low glitch must not start a frame.
      @(negedge clk);
      rx = 1'b0;
      waitCycles(5);
      rx = 1'b1;
      waitCycles(30);
      checkState("glitch");

      for (int n = 0; n < 10; n++) begin
         logic [7:0] d;
         logic       sb;
         d  = 8'($urandom_range(0, 255));
         sb = ($urandom_range(0, 3) != 0);
         sendAndModel(d, sb);
         checkState($sformatf("rnd%0d", n));
         if (modelCount > 0) checkMem(modelCount - 1);
      end

      // Dropping Load in bit 4 aborts the frame; RX is ignored while Load is low.
      @(negedge clk);
      rx = 1'b0;
      waitCycles(BIT_CYC);
      for (int i = 0; i < 8; i++) begin
         rx = logic'((8'hA5 >> i) & 8'h01);
         if (i == 4) begin
            waitCycles(8);
            load = 1'b0;
            waitCycles(BIT_CYC - 8);
         end else begin
            waitCycles(BIT_CYC);
         end
      end
      rx = 1'b1;
      waitCycles(BIT_CYC + 6);
      checkState("loaddrop");
      applyStimulus(8'h3C, 1'b1);
      checkState("load0_rx");

      load = 1'b1;
      modelLoadRise();
      waitCycles(2);
      for (int b = 0; b < 33; b++) begin
         sendAndModel(8'(b), 1'b1);
         if (b == 31) checkState("full32");
      end
      checkState("full33");
      checkOutput("full_flag", 32'(full), 32'd1);
      pc = ADDR_W'(31);
      #1;
      checkOutput("mem31_const", 32'(dataOut), 32'h1F);
      for (int a = 0; a < DEPTH; a++) checkMem(a);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
